// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: oversampled deframer with one-entry valid/ready holding register.
// Optional define UART_RX_MAJORITY_EN: 2-of-3 majority bit decisions around each sample point.
module uart_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int OSR_NORM    = 16,
    parameter int OSR_LOW     = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bclk,
    input  logic       mode_osl,
    input  logic       rxd,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic [7:0] rx_data,
    output logic       rx_pe,
    output logic       rx_fe,
    output logic       rx_bi,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_oe,
    output logic       rx_busy
);

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // The decision lands one tick late in majority mode; the bit-to-bit spacing stays OSR.
    localparam logic [4:0] START_N = 5'(OSR_NORM / 2 - 1 + MAJ);
    localparam logic [4:0] START_L = 5'(OSR_LOW / 2 - 1 + MAJ);
    localparam logic [4:0] FULL_N  = 5'(OSR_NORM - 1);
    localparam logic [4:0] FULL_L  = 5'(OSR_LOW - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [4:0]             cnt_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shreg_q;
    logic                   any_one_q, par_err_q, done_q;
    logic                   osl_q, pen_q, eps_q, sp_q;
    logic [1:0]             wls_q;
    logic [7:0]             fr_data_q;
    logic                   fr_pe_q, fr_fe_q, fr_bi_q;
    logic [7:0]             rx_data_q;
    logic                   rx_pe_q, rx_fe_q, rx_bi_q, rx_valid_q, rx_oe_q;

    logic       rxd_s, bit_smp, exp_par, brk;
    logic [4:0] start_pt, full_pt;
    logic [7:0] data_aligned;

    assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;
    always_ff @(posedge clk) begin
        if (rst)       hist_q <= 2'b11;
        else if (bclk) hist_q <= {hist_q[0], rxd_s};
    end
    assign bit_smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
`else
    assign bit_smp = rxd_s;
`endif

    always_comb begin
        start_pt     = osl_q ? START_L : START_N;
        full_pt      = osl_q ? FULL_L : FULL_N;
        // Bits enter at the top, so an N-bit word sits in [7:8-N]; ~wls_q equals 8-N.
        data_aligned = shreg_q >> (~wls_q);
        exp_par      = sp_q ? ~eps_q : (eps_q ? ^data_aligned : ~^data_aligned);
        brk          = ~bit_smp & ~any_one_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            any_one_q <= 1'b0;
            par_err_q <= 1'b0;
            done_q    <= 1'b0;
            osl_q     <= 1'b0;
            wls_q     <= 2'b00;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            sp_q      <= 1'b0;
            fr_data_q <= '0;
            fr_pe_q   <= 1'b0;
            fr_fe_q   <= 1'b0;
            fr_bi_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            done_q <= 1'b0;
            if (bclk) begin
                case (state_q)
                    IDLE: if (!rxd_s) begin
                        cnt_q   <= '0;
                        osl_q   <= mode_osl;
                        wls_q   <= wls;
                        pen_q   <= pen;
                        eps_q   <= eps;
                        sp_q    <= sp;
                        state_q <= START;
                    end
                    START: if (cnt_q == start_pt) begin
                        if (bit_smp) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q     <= '0;
                            bit_cnt_q <= '0;
                            any_one_q <= 1'b0;
                            par_err_q <= 1'b0;
                            state_q   <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                    DATA: if (cnt_q == full_pt) begin
                        cnt_q     <= '0;
                        shreg_q   <= {bit_smp, shreg_q[7:1]};
                        any_one_q <= any_one_q | bit_smp;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == {1'b1, wls_q})
                            state_q <= pen_q ? PARITY : STOP;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                    PARITY: if (cnt_q == full_pt) begin
                        cnt_q     <= '0;
                        par_err_q <= bit_smp ^ exp_par;
                        any_one_q <= any_one_q | bit_smp;
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                    STOP: if (cnt_q == full_pt) begin
                        cnt_q     <= '0;
                        done_q    <= 1'b1;
                        fr_fe_q   <= ~bit_smp;
                        fr_bi_q   <= brk;
                        fr_pe_q   <= par_err_q;
                        fr_data_q <= brk ? 8'h00 : data_aligned;
                        state_q   <= brk ? BRK_WAIT : IDLE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                    BRK_WAIT: if (rxd_s) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Holding register: a completed frame either loads or, if the slot is still owned, overruns.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_pe_q    <= 1'b0;
            rx_fe_q    <= 1'b0;
            rx_bi_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_oe_q    <= 1'b0;
        end else begin
            rx_oe_q <= 1'b0;
            if (done_q) begin
                if (rx_valid_q && !rx_ready) begin
                    rx_oe_q <= 1'b1;
                end else begin
                    rx_data_q  <= fr_data_q;
                    rx_pe_q    <= fr_pe_q;
                    rx_fe_q    <= fr_fe_q;
                    rx_bi_q    <= fr_bi_q;
                    rx_valid_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_pe    = rx_pe_q;
    assign rx_fe    = rx_fe_q;
    assign rx_bi    = rx_bi_q;
    assign rx_valid = rx_valid_q;
    assign rx_oe    = rx_oe_q;
    assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: directed cases plus a randomized scoreboard run.
module tb_uart_rx;
    logic       clk = 1'b0, rst = 1'b1, bclk = 1'b0, mode_osl = 1'b0, rxd = 1'b1;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0, eps = 1'b0, sp = 1'b0, rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_pe, rx_fe, rx_bi, rx_valid, rx_oe, rx_busy;

    int          n_checks = 0, n_fail = 0, oe_cnt = 0, cur_osr = 16, bdiv = 0;
    bit          sb_en = 1'b0;
    logic [10:0] exp_q[$];

    uart_rx dut (
        .clk(clk), .rst(rst), .bclk(bclk), .mode_osl(mode_osl), .rxd(rxd),
        .wls(wls), .pen(pen), .eps(eps), .sp(sp),
        .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_oe(rx_oe), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Irregular oversample enable: one pulse every 2..4 clocks.
    always @(negedge clk) begin
        if (bdiv == 0) begin
            bclk = 1'b1;
            bdiv = $urandom_range(1, 3);
        end else begin
            bclk = 1'b0;
            bdiv = bdiv - 1;
        end
    end

    always @(negedge clk) if (rx_oe) oe_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) chk("sb_extra", {21'd0, rx_bi, rx_fe, rx_pe, rx_data}, 32'hFFFF_FFFF);
            else chk("sb_char", {21'd0, rx_bi, rx_fe, rx_pe, rx_data}, {21'd0, exp_q.pop_front()});
        end
    end

    // Expected {bi, fe, pe, data} from the line bits of one frame.
    function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] w, input logic p,
                                          input logic e, input logic s, input logic pbit,
                                          input logic stop);
        logic [7:0] dd;
        logic       ep, pe_x, fe_x, bi_x;
        dd = 8'h00;
        for (int i = 0; i < 5 + int'(w); i++) dd[i] = d[i];
        ep   = s ? ~e : (e ? ^dd : ~^dd);
        pe_x = p && (pbit != ep);
        fe_x = !stop;
        bi_x = (dd == 8'h00) && (!p || !pbit) && !stop;
        return {bi_x, fe_x, pe_x, bi_x ? 8'h00 : dd};
    endfunction

    task automatic tick();
        do @(posedge clk); while (!bclk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (cur_osr) tick();
    endtask

    task automatic send_char(input logic [7:0] d, input int nb, input logic pe_en,
                             input logic pbit, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pe_en) send_bit(pbit);
        send_bit(stop);
    endtask

    task automatic set_cfg(input logic o, input logic [1:0] w, input logic p, input logic e,
                           input logic s);
        mode_osl = o; wls = w; pen = p; eps = e; sp = s;
        cur_osr  = o ? 13 : 16;
    endtask

    task automatic pulse_ready();
        @(negedge clk) rx_ready = 1'b1;
        @(negedge clk) rx_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [1:0] w;
        logic       o, p, e, s, pb;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_data", rx_data, 0);
        chk("rst_flags", {rx_pe, rx_fe, rx_bi, rx_valid, rx_oe, rx_busy}, 0);
        rst = 1'b0;
        send_bit(1'b1);

        set_cfg(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        send_char(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("8n1_valid", rx_valid, 1);
        chk("8n1_data", rx_data, 8'hA5);
        chk("8n1_flags", {rx_pe, rx_fe, rx_bi}, 0);
        pulse_ready();
        chk("8n1_accept", rx_valid, 0);

        set_cfg(1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
        send_char(8'h35, 7, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("7e1_bad_pe", rx_pe, 1);
        chk("7e1_bad_data", rx_data, 8'h35);
        pulse_ready();
        send_char(8'h35, 7, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("7e1_good_pe", rx_pe, 0);
        chk("7e1_good_data", {rx_valid, rx_data}, {1'b1, 8'h35});
        pulse_ready();

        set_cfg(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d_of(8'h3C, i));
        rxd = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        chk("fe_valid_data", {rx_valid, rx_data}, {1'b1, 8'h3C});
        chk("fe_flags", {rx_fe, rx_bi}, 2'b10);
        pulse_ready();
        repeat (11 * 16) tick();
        @(negedge clk);
        chk("brk_valid_data", {rx_valid, rx_data}, {1'b1, 8'h00});
        chk("brk_flags", {rx_bi, rx_fe}, 2'b11);
        chk("brk_busy", rx_busy, 1);
        rxd = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("brk_release", rx_busy, 0);
        pulse_ready();
        send_bit(1'b1);

        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        chk("glitch_busy", rx_busy, 0);
        chk("glitch_valid", rx_valid, 0);

        oe_cnt = 0;
        send_char(8'h11, 8, 1'b0, 1'b0, 1'b1);
        send_char(8'h22, 8, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovr_data", {rx_valid, rx_data}, {1'b1, 8'h11});
        chk("ovr_pulses", oe_cnt, 1);
        pulse_ready();

        oe_cnt = 0;
        send_char(8'h11, 8, 1'b0, 1'b0, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d_of(8'h22, i));
        rxd = 1'b1;
        for (int k = 0; k < 400 && rx_busy; k++) @(negedge clk);
        chk("simul_stop_seen", rx_busy, 0);
        rx_ready = 1'b1;
        @(negedge clk) rx_ready = 1'b0;
        chk("simul_data", {rx_valid, rx_data}, {1'b1, 8'h22});
        chk("simul_no_oe", oe_cnt, 0);
        repeat (cur_osr) tick();
        pulse_ready();

        set_cfg(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        send_char(8'h1F, 5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("13x_data", {rx_valid, rx_data}, {1'b1, 8'h1F});
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_data", rx_data, 0);
        chk("midrst_flags", {rx_pe, rx_fe, rx_bi, rx_valid, rx_oe, rx_busy}, 0);
        rxd = 1'b1;
        rst = 1'b0;
        send_bit(1'b1);
        send_char(8'h0A, 5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_data", {rx_valid, rx_data}, {1'b1, 8'h0A});
        chk("post_rst_flags", {rx_pe, rx_fe, rx_bi}, 0);
        pulse_ready();

        oe_cnt   = 0;
        rx_ready = 1'b1;
        sb_en    = 1'b1;
        for (int n = 0; n < 30; n++) begin
            d  = 8'($urandom);
            w  = 2'($urandom);
            o  = 1'($urandom);
            p  = 1'($urandom);
            e  = 1'($urandom);
            s  = 1'($urandom);
            pb = 1'($urandom);
            set_cfg(o, w, p, e, s);
            exp_q.push_back(model(d, w, p, e, s, pb, 1'b1));
            send_bit(1'b0);
            // Configuration is latched at start detection; scrambling it now must not matter.
            mode_osl = 1'($urandom); wls = 2'($urandom); pen = 1'($urandom);
            eps = 1'($urandom); sp = 1'($urandom);
            for (int i = 0; i < 5 + int'(w); i++) send_bit(d[i]);
            if (p) send_bit(pb);
            send_bit(1'b1);
            if ($urandom_range(0, 1) == 1) send_bit(1'b1);
        end
        repeat (8) tick();
        @(negedge clk);
        sb_en = 1'b0;
        chk("sb_drain", exp_q.size(), 0);
        chk("sb_no_oe", oe_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    function automatic logic d_of(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
